// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Connects a core's load/store requests to a 64-bit data memory that is
//   dword wide. Loads of any size read one dword and then extract the
//   requested field, with sign or zero extension. A dword store writes
//   directly. Byte, half and word stores use read-modify-write: the unit reads
//   the dword, merges in the new bytes, and writes the dword back. The unit
//   checks alignment when it accepts a request. A misaligned request returns
//   a fault response and does not touch memory.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req_valid           core presents a request
//   o_req_ready           unit idle, can accept a request
//   i_req_write           1 = store, 0 = load
//   i_req_size            00 byte, 01 half, 10 word, 11 dword
//   i_req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   i_req_addr            byte address
//   i_req_wdata           store data, right-justified
//   o_resp_valid          one-cycle completion pulse
//   o_resp_rdata          extended load data (0 for stores / faults)
//   o_resp_misaligned     alignment fault flag, qualified by o_resp_valid
//   o_mem_read            memory read strobe
//   o_mem_write           memory write strobe
//   o_mem_addr            dword-aligned memory address
//   o_mem_wdata           dword to write
//   i_mem_rdata           combinational memory read data
// ---------------------------------------------------------------------------
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_misaligned,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_mem_wdata,
    input  logic [63:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_STORE  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_unsigned;
    logic [63:0] r_wdata;
    logic        r_misaligned;
    logic [63:0] r_rdata;

    logic        w_accept;
    logic        w_req_misaligned;
    logic [2:0]  w_offset;
    logic [3:0]  w_nbytes;
    logic [3:0]  w_end;
    logic [7:0]  w_byte_en;
    logic [63:0] w_wdata_shifted;
    logic [63:0] w_merged;
    logic [63:0] w_field;
    logic [63:0] w_load_data;

    assign w_accept = i_req_valid && (r_state == S_IDLE);

    // Natural alignment: the address must be a multiple of the access size.
    always_comb begin
        w_req_misaligned = 1'b0;
        case (i_req_size)
            2'b00:   w_req_misaligned = 1'b0;
            2'b01:   w_req_misaligned = i_req_addr[0];
            2'b10:   w_req_misaligned = |i_req_addr[1:0];
            default: w_req_misaligned = |i_req_addr[2:0];
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_misaligned) begin
                        w_next_state = S_RESP;
                    end else if (!i_req_write) begin
                        w_next_state = S_LOAD;
                    end else if (i_req_size == 2'b11) begin
                        w_next_state = S_STORE;
                    end else begin
                        w_next_state = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   w_next_state = S_RESP;
            S_RMW_RD: w_next_state = S_RMW_WR;
            S_RMW_WR: w_next_state = S_RESP;
            S_STORE:  w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_size       <= '0;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_wdata      <= '0;
            r_misaligned <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_addr       <= i_req_addr;
                r_size       <= i_req_size;
                r_write      <= i_req_write;
                r_unsigned   <= i_req_unsigned;
                r_wdata      <= i_req_wdata;
                r_misaligned <= w_req_misaligned;
            end
            if ((r_state == S_LOAD) || (r_state == S_RMW_RD)) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store merge: bytes [offset, offset+nbytes) come from the shifted
    // write data, and all other bytes keep the captured dword.
    // ------------------------------------------------------------------
    assign w_offset        = r_addr[2:0];
    assign w_nbytes        = 4'd1 << r_size;
    assign w_end           = {1'b0, w_offset} + w_nbytes;
    assign w_wdata_shifted = r_wdata << {w_offset, 3'b000};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_merge
            localparam logic [3:0] LP_IDX = 4'(gi);
            assign w_byte_en[gi] = (LP_IDX >= {1'b0, w_offset}) && (LP_IDX < w_end);
            assign w_merged[gi*8 +: 8] = w_byte_en[gi] ? w_wdata_shifted[gi*8 +: 8]
                                                       : r_rdata[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load extraction: shift the field down, then truncate and extend it
    // ------------------------------------------------------------------
    assign w_field = r_rdata >> {w_offset, 3'b000};

    always_comb begin
        w_load_data = w_field;
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {56'd0, w_field[7:0]}
                                              : {{56{w_field[7]}}, w_field[7:0]};
            2'b01:   w_load_data = r_unsigned ? {48'd0, w_field[15:0]}
                                              : {{48{w_field[15]}}, w_field[15:0]};
            2'b10:   w_load_data = r_unsigned ? {32'd0, w_field[31:0]}
                                              : {{32{w_field[31]}}, w_field[31:0]};
            default: w_load_data = w_field;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The strobes are decoded from the state only, so an
    // asynchronous reset removes them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        o_req_ready       = 1'b0;
        o_resp_valid      = 1'b0;
        o_resp_rdata      = '0;
        o_resp_misaligned = 1'b0;
        o_mem_read        = 1'b0;
        o_mem_write       = 1'b0;
        o_mem_wdata       = '0;
        o_mem_addr        = {r_addr[63:3], 3'b000};
        case (r_state)
            S_IDLE:   o_req_ready = 1'b1;
            S_LOAD:   o_mem_read  = 1'b1;
            S_RMW_RD: o_mem_read  = 1'b1;
            S_RMW_WR: begin
                o_mem_write = 1'b1;
                o_mem_wdata = w_merged;
            end
            S_STORE: begin
                o_mem_write = 1'b1;
                o_mem_wdata = r_wdata;
            end
            S_RESP: begin
                o_resp_valid      = 1'b1;
                o_resp_misaligned = r_misaligned;
                o_resp_rdata      = (r_misaligned || r_write) ? 64'd0 : w_load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose:
//   Self-checking bench for load_store_unit. The bench models the data memory
//   as a dword array that reads combinationally and writes on the clock edge.
//   The reference model is a flat byte array that is updated one transaction
//   at a time. From it the bench derives the expected load values, memory
//   contents, fault flags, latencies and strobe counts.
//
// Ports: none (top-level testbench).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_write       (req_write),
        .i_req_size        (req_size),
        .i_req_unsigned    (req_unsigned),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .o_resp_valid      (resp_valid),
        .o_resp_rdata      (resp_rdata),
        .o_resp_misaligned (resp_misaligned),
        .o_mem_read        (mem_read),
        .o_mem_write       (mem_write),
        .o_mem_addr        (mem_addr),
        .o_mem_wdata       (mem_wdata),
        .i_mem_rdata       (mem_rdata)
    );

    // Environment memory: 16 dwords, aliased on address bits [6:3].
    logic [63:0] tb_mem [0:15];
    assign mem_rdata = tb_mem[mem_addr[6:3]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[6:3]] <= mem_wdata;
    end

    // Reference model: the same 128 bytes, one byte at a time.
    logic [7:0] ref_bytes [0:127];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v = v | (64'(ref_bytes[idx*8 + k]) << (8*k));
        return v;
    endfunction

    function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [63:0] addr);
        int nb = 1 << sz;
        int base = int'(addr[6:0]);
        logic [63:0] v = '0;
        for (int k = 0; k < nb; k++) v = v | (64'(ref_bytes[base + k]) << (8*k));
        if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
        return v;
    endfunction

    // Run one request and check it against the model. The task returns the
    // observed response data and the last dword written to memory.
    task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] got_rdata, output logic [63:0] got_wdata);
        int          nb;
        logic        exp_mis;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [63:0] exp_rdata;
        logic [63:0] exp_word;
        logic [63:0] exp_maddr;
        int          idx;
        int          lat;
        int          reads;
        int          writes;
        logic        got_mis;
        logic        got;

        nb        = 1 << sz;
        idx       = int'(addr[6:3]);
        exp_mis   = (addr % 64'(nb)) != 0;
        exp_lat   = exp_mis ? 1 : ((!wr || nb == 8) ? 2 : 3);
        exp_reads = (exp_mis || (wr && nb == 8)) ? 0 : 1;
        exp_writes = (exp_mis || !wr) ? 0 : 1;
        exp_rdata = (exp_mis || wr) ? 64'd0 : ref_load(sz, uns, addr);
        exp_maddr = addr & ~64'd7;
        if (!exp_mis && wr) begin
            for (int k = 0; k < nb; k++) ref_bytes[int'(addr[6:0]) + k] = wdata[8*k +: 8];
        end
        exp_word = ref_word(idx);

        @(negedge clk);
        check({name, ".ready"}, 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        // Scramble the inputs: the request has already been latched.
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};

        lat = 0; reads = 0; writes = 0; got = 1'b0;
        got_rdata = '0; got_wdata = '0; got_mis = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read) begin
                reads++;
                check({name, ".rd_addr"}, mem_addr, exp_maddr);
            end
            if (mem_write) begin
                writes++;
                got_wdata = mem_wdata;
                check({name, ".wr_addr"}, mem_addr, exp_maddr);
            end
            if (resp_valid) begin
                lat       = c;
                got_rdata = resp_rdata;
                got_mis   = resp_misaligned;
                got       = 1'b1;
                break;
            end
        end
        check({name, ".latency"}, 64'(lat), 64'(exp_lat));
        check({name, ".rdata"}, got_rdata, exp_rdata);
        check({name, ".misaligned"}, 64'(got_mis), 64'(exp_mis));
        check({name, ".reads"}, 64'(reads), 64'(exp_reads));
        check({name, ".writes"}, 64'(writes), 64'(exp_writes));
        if (exp_writes != 0) check({name, ".wdata"}, got_wdata, exp_word);

        @(negedge clk);
        check({name, ".resp_drop"}, {62'd0, resp_valid, resp_misaligned}, 64'd0);
        check({name, ".rdata_idle"}, resp_rdata, 64'd0);
        check({name, ".ready_after"}, 64'(req_ready), 64'd1);
        check({name, ".mem_word"}, tb_mem[idx], exp_word);
        $display("txn %-10s wr=%0d size=%0d uns=%0d addr=%h lat=%0d rdata=%h mis=%0d got=%0d",
                 name, wr, sz, uns, addr, lat, got_rdata, got_mis, got);
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] wd;
        int          seen_w;
        int          seen_r;

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) tb_mem[i] = {$urandom, $urandom};
        tb_mem[0] = 64'h5;
        tb_mem[1] = 64'h1122334455667788;
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 8; k++) ref_bytes[i*8 + k] = tb_mem[i][8*k +: 8];

        // Outputs while reset is held
        @(negedge clk);
        check("rst.ready", 64'(req_ready), 64'd1);
        check("rst.strobes", {61'd0, resp_valid, mem_read, mem_write}, 64'd0);
        check("rst.resp", {resp_rdata[62:0], resp_misaligned}, 64'd0);
        check("rst.mem_addr", mem_addr, 64'd0);
        check("rst.mem_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        do_req("dw_load", 1'b0, 2'b11, 1'b0, 64'h0, 64'h0, rd, wd);
        check("dw_load.const", rd, 64'h5);
        do_req("b_store", 1'b1, 2'b00, 1'b0, 64'h9, 64'hAB, rd, wd);
        check("b_store.const", wd, 64'h112233445566AB88);
        do_req("b_load_s", 1'b0, 2'b00, 1'b0, 64'h9, 64'h0, rd, wd);
        check("b_load_s.const", rd, 64'hFFFFFFFFFFFFFFAB);
        do_req("b_load_u", 1'b0, 2'b00, 1'b1, 64'h9, 64'h0, rd, wd);
        check("b_load_u.const", rd, 64'h00000000000000AB);
        do_req("h_misal", 1'b0, 2'b01, 1'b0, 64'h3, 64'h0, rd, wd);
        check("h_misal.const", rd, 64'h0);

        // Reset during RMW_RD of a word store to 0x10
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'h10; req_wdata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rrst.in_rmw_rd", 64'(mem_read), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rrst.async_drop", {62'd0, mem_read, mem_write}, 64'd0);
        check("rrst.ready", 64'(req_ready), 64'd1);
        seen_w = 0; seen_r = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_write) seen_w++;
            if (resp_valid) seen_r++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_write) seen_w++;
            if (resp_valid) seen_r++;
        end
        check("rrst.no_write", 64'(seen_w), 64'd0);
        check("rrst.no_resp", 64'(seen_r), 64'd0);
        check("rrst.word2", tb_mem[2], ref_word(2));
        check("rrst.ready_rel", 64'(req_ready), 64'd1);
        do_req("dw_store", 1'b1, 2'b11, 1'b0, 64'h10, 64'h0123456789ABCDEF, rd, wd);
        check("dw_store.const", tb_mem[2], 64'h0123456789ABCDEF);

        // Randomized traffic against the byte-array model
        for (int t = 0; t < 60; t++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            do_req($sformatf("rnd%0d", t), 1'($urandom), 2'($urandom), 1'($urandom),
                   a, {$urandom, $urandom}, rd, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
